// File: rtl/spad_pkg.sv
// Shared defaults and drain FSM state encoding for the scratchpad read-out engine.
package spad_pkg;

    localparam int unsigned SPAD_AW_DEF = 8;
    localparam int unsigned SPAD_DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } drain_state_e;

endpackage

// File: rtl/spad_drain_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata shows the head entry (zero when empty).
module spad_drain_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/spad_drain.sv
// Scratchpad read-out engine: drains count words from base onto a valid/ready stream.
// Optional SPAD_DRAIN_SUM_EN adds a running sum of all transferred words on port sum.
module spad_drain
    import spad_pkg::*;
#(
    parameter int unsigned SPAD_AW    = SPAD_AW_DEF,
    parameter int unsigned SPAD_DW    = SPAD_DW_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SPAD_AW-1:0] base,
    input  logic [SPAD_AW:0]   count,
    output logic               busy,
    output logic               done,
    output logic               mem_en,
    output logic               mem_we,
    output logic [SPAD_AW-1:0] mem_addr,
    output logic [SPAD_DW-1:0] mem_di,
    input  logic [SPAD_DW-1:0] mem_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SPAD_DW-1:0] out_data,
    output logic               out_last
`ifdef SPAD_DRAIN_SUM_EN
    ,
    output logic [SPAD_DW-1:0] sum
`endif
);

    localparam int unsigned CNT_W = SPAD_AW + 1;
    localparam int unsigned FCW   = $clog2(FIFO_DEPTH + 1);

    drain_state_e       state_q, state_d;
    logic [SPAD_AW-1:0] base_q;
    logic [CNT_W-1:0]   count_q, issued_q, beats_q;
    logic               inflight_q;
    logic [FCW-1:0]     fifo_count;
    logic [FCW:0]       occ;
    logic               fifo_empty, fifo_full, pop, accept;

    assign mem_we    = 1'b0;
    assign mem_di    = '0;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (beats_q == count_q - 1'b1);
    assign accept    = (state_q == IDLE) && start;
    // Words already owed to the FIFO: buffered now plus the one read landing this cycle.
    assign occ       = (FCW + 1)'(fifo_count) + (FCW + 1)'(inflight_q);
    assign mem_addr  = mem_en ? base_q + issued_q[SPAD_AW-1:0] : '0;

    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy    = 1'b1;
                    state_d = (count == '0) ? FINISH : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (issued_q < count_q && occ < (FCW + 1)'(FIFO_DEPTH) && !fifo_full) begin
                    mem_en = 1'b1;
                end
                if (issued_q + CNT_W'(mem_en) == count_q) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!inflight_q && (fifo_empty || (fifo_count == FCW'(1) && pop))) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            beats_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= mem_en;
            if (accept) begin
                base_q   <= base;
                count_q  <= count;
                issued_q <= '0;
                beats_q  <= '0;
            end else begin
                if (mem_en) issued_q <= issued_q + 1'b1;
                if (pop)    beats_q  <= beats_q + 1'b1;
            end
        end
    end

    spad_drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SPAD_DW),
        .CW    (FCW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .wdata (mem_dout),
        .pop   (pop),
        .rdata (out_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef SPAD_DRAIN_SUM_EN
    logic [SPAD_DW-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + out_data;
        end
    end

    assign sum = sum_q;
`endif

endmodule

// File: tb/tb_spad_drain.sv
// Randomised self-checking bench for spad_drain against a behavioural scratchpad/stream model.
module tb_spad_drain;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base = '0;
    logic [8:0]  count = '0;
    logic        busy, done, mem_en, mem_we, out_valid, out_last;
    logic [7:0]  mem_addr;
    logic [31:0] mem_di, out_data;
    logic [31:0] mem_dout = '0;
    logic        out_ready = 1'b1;
`ifdef SPAD_DRAIN_SUM_EN
    logic [31:0] sum;
`endif

    spad_drain #(
        .SPAD_AW    (8),
        .SPAD_DW    (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_di    (mem_di),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef SPAD_DRAIN_SUM_EN
        ,
        .sum       (sum)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad model: registered read, data valid the cycle after mem_en.
    logic [31:0] ram [256];
    always @(posedge clk) if (mem_en) mem_dout <= ram[mem_addr];

    logic [31:0] data_q[$];
    bit          last_q[$];
    int          bcyc_q[$];
    logic [7:0]  addr_q[$];
    int n_rd, n_beat, valid_seen, done_cnt, done_cyc, busy_cnt, first_en;
    bit we_seen, occ_bad, stab_bad, busy_at_done, prev_valid, prev_ready, prev_last;
    logic [31:0] prev_data, sum_at_done;

    always @(negedge clk) begin
        if (mem_we) we_seen = 1'b1;
        if (mem_en) begin
            if (n_rd - n_beat >= DEPTH) occ_bad = 1'b1;
            if (first_en < 0) first_en = cyc;
            addr_q.push_back(mem_addr);
            n_rd++;
        end
        if (prev_valid && !prev_ready &&
            !(out_valid && out_data === prev_data && out_last === prev_last))
            stab_bad = 1'b1;
        if (out_valid) valid_seen++;
        if (out_valid && out_ready) begin
            data_q.push_back(out_data);
            last_q.push_back(out_last);
            bcyc_q.push_back(cyc);
            n_beat++;
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) busy_at_done = 1'b1;
`ifdef SPAD_DRAIN_SUM_EN
            sum_at_done = sum;
`endif
        end
    end

    task automatic clear_logs();
        data_q.delete(); last_q.delete(); bcyc_q.delete(); addr_q.delete();
        n_rd = 0; n_beat = 0; valid_seen = 0; done_cnt = 0; done_cyc = -1;
        busy_cnt = 0; first_en = -1; we_seen = 0; occ_bad = 0; stab_bad = 0;
        busy_at_done = 0; prev_valid = 0; prev_ready = 0;
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random. mid>0 pulses a stray start.
    task automatic run_xfer(input logic [7:0] b, input logic [8:0] n, input int rmode,
                            input int mid, output int k, output bit tmo);
        clear_logs();
        out_ready = (rmode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
        start = 1'b1; base = b; count = n;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0; base = 8'($urandom); count = 9'($urandom);
        tmo = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (i % 4 == 0) || (i % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mid != 0 && i == mid) begin
                start = 1'b1; base = 8'(b + 8'd100); count = 9'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                tmo = 1'b0;
                break;
            end
        end
        start = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input logic [7:0] b, input int n);
        total++;
        if (data_q.size() != n) begin
            bad++;
            $display("FAIL %s beat_count: got %0d want %0d", tag, data_q.size(), n);
        end
        for (int i = 0; i < n && i < data_q.size(); i++) begin
            total++;
            if (data_q[i] !== ram[8'(b + i)] || last_q[i] !== (i == n - 1)) begin
                bad++;
                $display("FAIL %s beat[%0d]: got data=%h last=%0b want data=%h last=%0b",
                         tag, i, data_q[i], last_q[i], ram[8'(b + i)], (i == n - 1));
            end
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, mem_en, out_valid, out_last} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, mem_en, out_valid, out_last});
        end
        total++;
        if (mem_addr !== 8'd0 || out_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_buses: got addr=%h data=%h want 0", mem_addr, out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, out_valid, mem_en} !== 3'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 000", {busy, out_valid, mem_en});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_rate();
        int k; bit tmo;
        for (int i = 0; i < 9; i++) ram[i] = i;
        run_xfer(8'd0, 9'd9, 0, 0, k, tmo);
        total++;
        if (tmo) begin bad++; $display("FAIL full_rate timeout: got 1 want 0"); end
        check_stream("full_rate", 8'd0, 9);
        for (int i = 0; i < bcyc_q.size(); i++) begin
            total++;
            if (bcyc_q[i] != k + 2 + i) begin
                bad++;
                $display("FAIL full_rate beat_cycle[%0d]: got %0d want %0d", i, bcyc_q[i], k + 2 + i);
            end
        end
        total++;
        if (first_en != k || n_rd != 9) begin
            bad++;
            $display("FAIL full_rate reads: got first=%0d n=%0d want %0d 9", first_en, n_rd, k);
        end
        total++;
        if (done_cyc != k + 11 || busy_at_done) begin
            bad++;
            $display("FAIL full_rate done: got cyc=%0d busy=%0b want %0d 0", done_cyc, busy_at_done, k + 11);
        end
        total++;
        if (busy_cnt != 12 || we_seen) begin
            bad++;
            $display("FAIL full_rate busy_we: got busy=%0d we=%0b want 12 0", busy_cnt, we_seen);
        end
    endtask

    task automatic test_backpressure();
        int k; bit tmo;
        for (int i = 0; i < 9; i++) ram[i] = $urandom;
        run_xfer(8'd0, 9'd9, 1, 0, k, tmo);
        total++;
        if (tmo) begin bad++; $display("FAIL backpressure timeout: got 1 want 0"); end
        check_stream("backpressure", 8'd0, 9);
        total++;
        if (stab_bad || occ_bad) begin
            bad++;
            $display("FAIL backpressure rules: got stab=%0b occ=%0b want 0 0", stab_bad, occ_bad);
        end
    endtask

    task automatic test_wrap();
        int k; bit tmo;
        logic [7:0] exp_addr [4];
        exp_addr[0] = 8'd254; exp_addr[1] = 8'd255; exp_addr[2] = 8'd0; exp_addr[3] = 8'd1;
        for (int i = 0; i < 4; i++) ram[exp_addr[i]] = $urandom;
        run_xfer(8'd254, 9'd4, 0, 0, k, tmo);
        total++;
        if (tmo || addr_q.size() != 4) begin
            bad++;
            $display("FAIL wrap reads: got tmo=%0b n=%0d want 0 4", tmo, addr_q.size());
        end
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            total++;
            if (addr_q[i] !== exp_addr[i]) begin
                bad++;
                $display("FAIL wrap addr[%0d]: got %0d want %0d", i, addr_q[i], exp_addr[i]);
            end
        end
        check_stream("wrap", 8'd254, 4);
    endtask

    task automatic test_zero();
        int k; bit tmo;
        run_xfer(8'($urandom), 9'd0, 0, 0, k, tmo);
        total++;
        if (tmo || n_rd != 0 || valid_seen != 0) begin
            bad++;
            $display("FAIL zero activity: got tmo=%0b reads=%0d valid=%0d want 0 0 0",
                     tmo, n_rd, valid_seen);
        end
        total++;
        if (done_cyc != k || busy_cnt != 1 || done_cnt != 1) begin
            bad++;
            $display("FAIL zero timing: got done_cyc=%0d busy=%0d dones=%0d want %0d 1 1",
                     done_cyc, busy_cnt, done_cnt, k);
        end
    endtask

    task automatic test_reset_restart();
        int k; bit tmo; int nb;
        for (int i = 0; i < 9; i++) ram[i] = $urandom;
        clear_logs();
        out_ready = 1'b1; start = 1'b1; base = 8'd0; count = 9'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50 && n_beat < 3; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (n_beat < 3) begin bad++; $display("FAIL restart beats3: got %0d want 3", n_beat); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, mem_en, out_valid, out_last} !== 5'b0 || out_data !== 32'd0 ||
            mem_addr !== 8'd0) begin
            bad++;
            $display("FAIL restart abort: got flags=%b data=%h addr=%h want 0",
                     {busy, done, mem_en, out_valid, out_last}, out_data, mem_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        nb = n_beat;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 0 || n_beat != nb) begin
            bad++;
            $display("FAIL restart quiet: got dones=%0d beats=%0d want 0 %0d", done_cnt, n_beat, nb);
        end
        run_xfer(8'd0, 9'd2, 0, 0, k, tmo);
        check_stream("restart_two", 8'd0, 2);
        run_xfer(8'd0, 9'd9, 2, 4, k, tmo);
        check_stream("ignored_start", 8'd0, 9);
    endtask

    task automatic test_random();
        int k; bit tmo; logic [7:0] b; int n;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        for (int it = 0; it < 6; it++) begin
            b = 8'($urandom);
            n = (it == 0) ? 256 : int'($urandom_range(1, 40));
            run_xfer(b, 9'(n), 2, 0, k, tmo);
            total++;
            if (tmo || stab_bad || occ_bad || we_seen) begin
                bad++;
                $display("FAIL random[%0d] rules: got tmo=%0b stab=%0b occ=%0b we=%0b want 0",
                         it, tmo, stab_bad, occ_bad, we_seen);
            end
            check_stream("random", b, n);
        end
    endtask

`ifdef SPAD_DRAIN_SUM_EN
    task automatic test_sum();
        int k; bit tmo;
        for (int i = 0; i < 25; i++) ram[i] = i;
        run_xfer(8'd0, 9'd25, 2, 0, k, tmo);
        total++;
        if (tmo || sum_at_done !== 32'd300) begin
            bad++;
            $display("FAIL sum: got %0d want 300", sum_at_done);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        clear_logs();
        test_reset();
        test_full_rate();
        test_backpressure();
        test_wrap();
        test_zero();
        test_reset_restart();
        test_random();
`ifdef SPAD_DRAIN_SUM_EN
        test_sum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/spad_drain.md
Name: spad_drain

Overview:
- Scratchpad read-out engine: the reader end of the `rams_sp_nc` result scratchpad that `conv2d_3x3_lb` writes.
- On `start`, reads `count` consecutive 32-bit words from `base` through the single-port scratchpad interface.
- Streams them out on a valid/ready interface (with last-beat marker) toward host/DMA logic.
- Keeps one word per cycle in flight while honouring backpressure, with no loss or duplication.

Parameters:
- SPAD_AW, 8, scratchpad address width (256 words).
- SPAD_DW, 32, scratchpad/stream data width.
- FIFO_DEPTH, 4, output buffer entries; must be ≥3 to sustain one word per cycle.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only when idle.
- base  in  SPAD_AW  first word address, latched on start.
- count  in  SPAD_AW+1  words to drain, 0..256, latched on start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- mem_en  out  1  scratchpad enable (read strobe).
- mem_we  out  1  tied 0.
- mem_addr  out  SPAD_AW  read address.
- mem_di  out  SPAD_DW  tied 0.
- mem_dout  in  SPAD_DW  scratchpad read data, valid one cycle after mem_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer ready.
- out_data  out  SPAD_DW  stream word.
- out_last  out  1  high with the final word of the transfer.

Behaviour:
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0. FIFO is emptied, counters are cleared, state is IDLE.
- Reset mid-transfer aborts at once: no done pulse, and in-flight read data is discarded.
- FSM state IDLE:
  - start=1 latches base/count and sets busy.
  - count=0: go to FINISH.
  - otherwise: go to READ.
- FSM state READ:
  - Issue a read (mem_en=1, mem_addr=base+issued) when issued<count and fifo_count+inflight<FIFO_DEPTH.
  - fifo_count is the current occupancy before this cycle's pop.
  - inflight is 1 if mem_en was high last cycle.
  - Once all reads are issued, go to DRAIN.
- FSM state DRAIN: wait until the FIFO is empty, the last beat has handshaken and inflight=0, then go to FINISH.
- FSM state FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE.
- Address arithmetic is modulo 2^SPAD_AW; base=254, count=4 reads 254, 255, 0, 1.
- Read data is captured into the FIFO on the edge after mem_en's cycle; out_valid rises on that same edge.
  - If start is sampled at edge k, mem_en=1 during cycle k..k+1 and out_valid=1 from edge k+2.
- Stream rules:
  - out_valid, once high, holds with out_data/out_last stable until out_valid&&out_ready.
  - A beat transfers only on valid&&ready.
  - out_last=1 only on beat index count-1.
- With out_ready held high and FIFO_DEPTH≥3, beats are back-to-back: count words take count consecutive cycles.
- Simultaneous FIFO push and pop in one cycle is legal; occupancy is unchanged.
- start while busy is ignored; latched base/count are unchanged.

Optional Feature:
- Macro SPAD_DRAIN_SUM_EN; when defined, adds port `sum  out  SPAD_DW`.
  - `sum` is the wrap-around (mod 2^SPAD_DW) running sum of all words transferred on the stream.
  - `sum` is cleared on reset and on accepted start, and is stable and valid in the done cycle.
- Without the macro: no `sum` port and no adder.

Decomposition:
- Package spad_pkg: SPAD_AW/SPAD_DW defaults, drain FSM state enum (IDLE, READ, DRAIN, FINISH).
- Sub-module spad_drain_fifo: synchronous FIFO with push/pop/count/empty/full, parameterised by depth and width, first-word-fall-through output.

Test Plan:
- Full-rate drain: C preloaded with 0..8, base=0, count=9, out_ready=1 → out_data 0..8 on 9 consecutive cycles; out_last only with 8; done one cycle after last beat; mem_we never 1.
- Backpressure: base=0, count=9, out_ready toggling 1,0,0,1 pattern → out_data sequence still exactly 0..8 with no repeats or gaps; data stable while ready=0; mem_en never issued with FIFO+inflight full.
- Wrap-around: RAM[254]=A, [255]=B, [0]=C, [1]=D, base=254, count=4 → mem_addr 254, 255, 0, 1; stream A, B, C, D; out_last with D.
- Zero length: count=0 → no mem_en, no out_valid; busy 1 cycle, done pulse one cycle later.
- Reset/restart: reset asserted after 3 beats of a 9-word transfer → all outputs zero next edge, no done; new start base=0, count=2 yields 0, 1 cleanly; start pulsed mid-transfer is ignored.
- SPAD_DRAIN_SUM_EN: C=0..24, count=25 → sum=300 at done; without macro, the module compiles with no `sum` port.
